dhtk_main_control: RTL and testbench



---
 rtl/dhtk_main_control.sv | 131 +++++++++++++
 tb/tb_dhtk_main_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dhtk_main_control.sv
// dhtk_main_control: free-running clock/calendar core.
// A prescaler divides clk down to one tick per second; on each tick a
// ripple-carry cascade advances sec -> min -> hour -> day -> month -> year
// within the same edge, using Gregorian month lengths and leap years.
module dhtk_main_control #(
  parameter int TICKS_PER_SEC = 1,
  parameter int INIT_SEC      = 0,
  parameter int INIT_MIN      = 0,
  parameter int INIT_HOUR     = 0,
  parameter int INIT_DAY      = 1,
  parameter int INIT_MONTH    = 1,
  parameter int INIT_YEAR     = 2000
) (
  input  logic        clk,
  input  logic        rst_p,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic [4:0]  hour,
  output logic [4:0]  day,
  output logic [3:0]  month,
  output logic [11:0] year
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;

  logic          leap;
  logic [4:0]    dim;

  logic [5:0]    sec_n;
  logic [5:0]    min_n;
  logic [4:0]    hour_n;
  logic [4:0]    day_n;
  logic [3:0]    month_n;
  logic [11:0]   year_n;

  // With TICKS_PER_SEC=1 the counter stays at 0 and every edge is a tick.
  assign tick = (pre_cnt == PW'(TICKS_PER_SEC - 1));

  // Prescaler: counts 0..TICKS_PER_SEC-1 and restarts on the tick edge.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Leap year from the current year; year 0 is divisible by 400 so it is leap.
  always_comb begin
    leap = 1'b0;
    if ((year % 12'd400) == 12'd0) begin
      leap = 1'b1;
    end else if ((year[1:0] == 2'b00) && ((year % 12'd100) != 12'd0)) begin
      leap = 1'b1;
    end
  end

  // Days in the current (pre-increment) month.
  always_comb begin
    dim = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  end

  // Ripple-carry cascade: each field wraps and carries only when every
  // lower field wraps on the same tick.
  always_comb begin
    sec_n   = sec;
    min_n   = min;
    hour_n  = hour;
    day_n   = day;
    month_n = month;
    year_n  = year;
    if (tick) begin
      if (sec != 6'd59) begin
        sec_n = sec + 6'd1;
      end else begin
        sec_n = 6'd0;
        if (min != 6'd59) begin
          min_n = min + 6'd1;
        end else begin
          min_n = 6'd0;
          if (hour != 5'd23) begin
            hour_n = hour + 5'd1;
          end else begin
            hour_n = 5'd0;
            if (day != dim) begin
              day_n = day + 5'd1;
            end else begin
              day_n = 5'd1;
              if (month != 4'd12) begin
                month_n = month + 4'd1;
              end else begin
                month_n = 4'd1;
                year_n  = (year == 12'd4095) ? 12'd0 : year + 12'd1;
              end
            end
          end
        end
      end
    end
  end

  // Calendar registers; reset wins over any tick, including a full rollover.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      sec   <= 6'(INIT_SEC);
      min   <= 6'(INIT_MIN);
      hour  <= 5'(INIT_HOUR);
      day   <= 5'(INIT_DAY);
      month <= 4'(INIT_MONTH);
      year  <= 12'(INIT_YEAR);
    end else begin
      sec   <= sec_n;
      min   <= min_n;
      hour  <= hour_n;
      day   <= day_n;
      month <= month_n;
      year  <= year_n;
    end
  end

endmodule

// File: tb/tb_dhtk_main_control.sv
// Bench for dhtk_main_control: several instances with different parameter
// sets share one clock. A reference model derives each expected calendar
// from its INIT values plus (edges since reset / TICKS_PER_SEC) seconds.
module tb_dhtk_main_control;

  localparam int N = 11;

  localparam int TPS    [N] = '{1, 1, 1, 1, 1, 1, 1, 1, 4, 3, 1};
  localparam int I_SEC  [N] = '{0, 59, 59, 59, 59, 59, 59, 59, 0, 57, 59};
  localparam int I_MIN  [N] = '{0, 59, 59, 59, 59, 59, 59, 59, 0, 59, 59};
  localparam int I_HOUR [N] = '{0, 23, 23, 23, 23, 23, 23, 23, 0, 23, 23};
  localparam int I_DAY  [N] = '{1, 31, 28, 28, 28, 28, 30, 31, 1, 31, 29};
  localparam int I_MON  [N] = '{1, 12, 2, 2, 2, 2, 4, 12, 1, 12, 2};
  localparam int I_YEAR [N] = '{2000, 2023, 2023, 2024, 1900, 2000, 2023, 4095, 2000, 2099, 2024};

  typedef struct {
    int sec;
    int min;
    int hour;
    int day;
    int month;
    int year;
  } cal_t;

  logic          clk;
  logic [N-1:0]  rst;
  logic [5:0]    sec_a   [N];
  logic [5:0]    min_a   [N];
  logic [4:0]    hour_a  [N];
  logic [4:0]    day_a   [N];
  logic [3:0]    month_a [N];
  logic [11:0]   year_a  [N];

  int edges [N];
  int total;
  int bad;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dhtk_main_control #(
      .TICKS_PER_SEC (TPS[g]),
      .INIT_SEC      (I_SEC[g]),
      .INIT_MIN      (I_MIN[g]),
      .INIT_HOUR     (I_HOUR[g]),
      .INIT_DAY      (I_DAY[g]),
      .INIT_MONTH    (I_MON[g]),
      .INIT_YEAR     (I_YEAR[g])
    ) u_dut (
      .clk   (clk),
      .rst_p (rst[g]),
      .sec   (sec_a[g]),
      .min   (min_a[g]),
      .hour  (hour_a[g]),
      .day   (day_a[g]),
      .month (month_a[g]),
      .year  (year_a[g])
    );
  end

  // Model bookkeeping: edges since the last reset edge, per instance.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      edges[i] <= rst[i] ? 0 : edges[i] + 1;
    end
  end

  function automatic bit is_leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int days_in(int mo, int y);
    case (mo)
      4, 6, 9, 11: return 30;
      2:           return is_leap(y) ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  // Calendar reached from instance i's INIT after n whole seconds.
  function automatic cal_t model(int i, int n);
    cal_t c;
    int t;
    int days;
    t      = I_HOUR[i] * 3600 + I_MIN[i] * 60 + I_SEC[i] + n;
    days   = t / 86400;
    t      = t % 86400;
    c.hour = t / 3600;
    c.min  = (t % 3600) / 60;
    c.sec  = t % 60;
    c.day  = I_DAY[i];
    c.month = I_MON[i];
    c.year = I_YEAR[i];
    for (int k = 0; k < days; k++) begin
      if (c.day < days_in(c.month, c.year)) begin
        c.day++;
      end else begin
        c.day = 1;
        if (c.month < 12) begin
          c.month++;
        end else begin
          c.month = 1;
          c.year  = (c.year + 1) % 4096;
        end
      end
    end
    return c;
  endfunction

  function automatic cal_t dut_cal(int i);
    cal_t c;
    c.sec   = int'(sec_a[i]);
    c.min   = int'(min_a[i]);
    c.hour  = int'(hour_a[i]);
    c.day   = int'(day_a[i]);
    c.month = int'(month_a[i]);
    c.year  = int'(year_a[i]);
    return c;
  endfunction

  task automatic check(string name, int i, cal_t exp);
    cal_t got;
    got = dut_cal(i);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s inst=%0d got %0d:%0d:%0d %0d/%0d/%0d want %0d:%0d:%0d %0d/%0d/%0d",
               name, i, got.hour, got.min, got.sec, got.day, got.month, got.year,
               exp.hour, exp.min, exp.sec, exp.day, exp.month, exp.year);
    end
  endtask

  task automatic check_lit(string name, int i, int h, int mi, int s, int d, int mo, int y);
    cal_t e;
    e.hour = h; e.min = mi; e.sec = s; e.day = d; e.month = mo; e.year = y;
    check(name, i, e);
  endtask

  // Advance one clock and compare every instance against the model.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("model", i, model(i, edges[i] / TPS[i]));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < N; i++) edges[i] = 0;
    rst = '1;

    // reset edge: INIT values visible
    cycle();
    check_lit("reset_default", 0, 0, 0, 0, 1, 1, 2000);
    check_lit("reset_tps4", 8, 0, 0, 0, 1, 1, 2000);
    check_lit("reset_init", 1, 23, 59, 59, 31, 12, 2023);
    rst = '0;

    // first tick: full cascades
    cycle();
    check_lit("first_sec", 0, 0, 0, 1, 1, 1, 2000);
    check_lit("new_year", 1, 0, 0, 0, 1, 1, 2024);
    check_lit("feb_2023", 2, 0, 0, 0, 1, 3, 2023);
    check_lit("feb_2024", 3, 0, 0, 0, 29, 2, 2024);
    check_lit("feb_1900", 4, 0, 0, 0, 1, 3, 1900);
    check_lit("feb_2000", 5, 0, 0, 0, 29, 2, 2000);
    check_lit("apr_2023", 6, 0, 0, 0, 1, 5, 2023);
    check_lit("year_wrap", 7, 0, 0, 0, 1, 1, 0);
    check_lit("leap_day_end", 10, 0, 0, 0, 1, 3, 2024);
    check_lit("tps4_hold1", 8, 0, 0, 0, 1, 1, 2000);

    cycle();
    cycle();
    check_lit("tps4_hold3", 8, 0, 0, 0, 1, 1, 2000);
    cycle();
    check_lit("tps4_first", 8, 0, 0, 1, 1, 1, 2000);

    // up to 60 edges after reset
    for (int k = 0; k < 56; k++) cycle();
    check_lit("sixty_sec", 0, 0, 1, 0, 1, 1, 2000);
    check_lit("tps4_sixty", 8, 0, 0, 15, 1, 1, 2000);

    // mid-count reset of the divided instance
    cycle();
    cycle();
    rst[8] = 1'b1;
    cycle();
    check_lit("tps4_midrst", 8, 0, 0, 0, 1, 1, 2000);
    rst[8] = 1'b0;
    cycle();
    cycle();
    cycle();
    check_lit("tps4_restart3", 8, 0, 0, 0, 1, 1, 2000);
    cycle();
    check_lit("tps4_restart4", 8, 0, 0, 1, 1, 1, 2000);

    // randomized resets, checked every cycle against the model
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        rst[i] = ($urandom_range(0, 199) == 0);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
